// File: rtl/bmc_pkg.sv
// Shared BMC (biphase-mark) definitions for the lighthouse transmitter and its
// receiver decoder, so both ends agree on word size and half-bit timing.
package bmc_pkg;

    localparam int BMC_DATA_WIDTH      = 17;
    localparam int BMC_HALF_BIT_CYCLES = 8;
    localparam int BMC_LEAD_CYCLES     = 20;
    localparam int BMC_TAIL_CYCLES     = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SEND,
        ST_TAIL
    } bmc_state_e;

    // Counter width for a counter running 0..bound-1, never narrower than 1 bit.
    function automatic int cnt_w(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/bmc_half_bit_timer.sv
// Half-bit timer: a reloading down-counter that emits a one-cycle tick every
// HALF_BIT_CYCLES cycles while enabled. While disabled it parks at the reload
// value, so the first tick lands exactly one half bit after enable rises.
module bmc_half_bit_timer
    import bmc_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = BMC_HALF_BIT_CYCLES
) (
    input  logic clk_25MHz,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int            CW     = cnt_w(HALF_BIT_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(HALF_BIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count down while enabled; reload on expiry, on disable and on reset.
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= RELOAD;
        end else if (!en || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/bmc_lighthouse_tx.sv
// Lighthouse BMC transmitter: takes one word per handshake, raises the
// envelope, waits a lead-in, sends the word MSB first as biphase-mark
// (edge at every bit start, extra mid-bit edge for a '1'), adds a closing
// edge and a tail, then drops the envelope. data_wire is never forced low
// between frames; it only returns to 0 on reset.
module bmc_lighthouse_tx
    import bmc_pkg::*;
#(
    parameter int DATA_WIDTH      = BMC_DATA_WIDTH,
    parameter int HALF_BIT_CYCLES = BMC_HALF_BIT_CYCLES,
    parameter int LEAD_CYCLES     = BMC_LEAD_CYCLES,
    parameter int TAIL_CYCLES     = BMC_TAIL_CYCLES
) (
    input  logic                  clk_25MHz,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  data_wire,
    output logic                  envelop_wire,
    output logic                  busy
);

    localparam int BW = cnt_w(DATA_WIDTH);
    localparam int LW = cnt_w(LEAD_CYCLES);
    localparam int TW = cnt_w(TAIL_CYCLES);

    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [LW-1:0] LEAD_LAST = LW'(LEAD_CYCLES - 1);
    localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_CYCLES - 1);

    bmc_state_e            state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic [LW-1:0]         lead_cnt;
    logic [TW-1:0]         tail_cnt;
    logic                  second_half;
    logic                  timer_en;
    logic                  tick;

    // The timer only runs during SEND; it is parked at its reload value
    // during LEAD, so the first tick arrives one half bit into bit 0.
    assign timer_en = (state == ST_SEND);

    bmc_half_bit_timer #(
        .HALF_BIT_CYCLES (HALF_BIT_CYCLES)
    ) u_half_bit_timer (
        .clk_25MHz (clk_25MHz),
        .reset_n   (reset_n),
        .en        (timer_en),
        .tick      (tick)
    );

    // Frame FSM with registered outputs: handshake, lead-in, bit serialiser, tail.
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            lead_cnt     <= '0;
            tail_cnt     <= '0;
            second_half  <= 1'b0;
            data_wire    <= 1'b0;
            envelop_wire <= 1'b0;
            tx_ready     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // tx_ready is high throughout IDLE, so tx_valid alone accepts.
                    if (tx_valid) begin
                        shreg        <= tx_data;
                        lead_cnt     <= '0;
                        state        <= ST_LEAD;
                        envelop_wire <= 1'b1;
                        tx_ready     <= 1'b0;
                        busy         <= 1'b1;
                    end
                end

                ST_LEAD: begin
                    if (lead_cnt == LEAD_LAST) begin
                        // Bit 0 starts with its leading edge.
                        lead_cnt    <= '0;
                        bit_cnt     <= '0;
                        second_half <= 1'b0;
                        data_wire   <= ~data_wire;
                        state       <= ST_SEND;
                    end else begin
                        lead_cnt <= lead_cnt + 1'b1;
                    end
                end

                ST_SEND: begin
                    if (tick) begin
                        if (!second_half) begin
                            // Mid-bit edge only for a '1'.
                            second_half <= 1'b1;
                            if (shreg[DATA_WIDTH-1]) begin
                                data_wire <= ~data_wire;
                            end
                        end else begin
                            // Bit end: the edge here is the next bit's leading
                            // edge, or the closing edge after the last bit.
                            second_half <= 1'b0;
                            data_wire   <= ~data_wire;
                            shreg       <= shreg << 1;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt  <= '0;
                                tail_cnt <= '0;
                                state    <= ST_TAIL;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end

                ST_TAIL: begin
                    if (tail_cnt == TAIL_LAST) begin
                        tail_cnt     <= '0;
                        state        <= ST_IDLE;
                        envelop_wire <= 1'b0;
                        tx_ready     <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        tail_cnt <= tail_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bmc_lighthouse_tx.sv
// Bench for bmc_lighthouse_tx: directed frames, a negedge line monitor that
// decodes the BMC waveform independently, and a word scoreboard.
module tb_bmc_lighthouse_tx;

    localparam int DW   = 17;
    localparam int H    = 8;
    localparam int LEAD = 20;
    localparam int TAIL = 16;
    localparam int DW2  = 8;
    localparam int H2   = 4;

    logic           clk_25MHz = 1'b0;
    logic           reset_n   = 1'b0;
    logic [DW-1:0]  tx_data   = '0;
    logic           tx_valid  = 1'b0;
    logic           tx_ready, data_wire, envelop_wire, busy;
    logic [DW2-1:0] tx_data2  = '0;
    logic           tx_valid2 = 1'b0;
    logic           tx_ready2, data_wire2, envelop_wire2, busy2;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] sb[$];
    logic [31:0] sb2[$];

    bmc_lighthouse_tx dut (
        .clk_25MHz    (clk_25MHz),
        .reset_n      (reset_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .data_wire    (data_wire),
        .envelop_wire (envelop_wire),
        .busy         (busy)
    );

    bmc_lighthouse_tx #(.DATA_WIDTH(DW2), .HALF_BIT_CYCLES(H2)) dut2 (
        .clk_25MHz    (clk_25MHz),
        .reset_n      (reset_n),
        .tx_data      (tx_data2),
        .tx_valid     (tx_valid2),
        .tx_ready     (tx_ready2),
        .data_wire    (data_wire2),
        .envelop_wire (envelop_wire2),
        .busy         (busy2)
    );

    always #20 clk_25MHz = ~clk_25MHz;
    always @(posedge clk_25MHz) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent frame model: t[] holds data toggle offsets from envelope rise.
    task automatic check_frame(input string tag, input int len, input int n, input int t[80],
                               input int hb, input int dw, input logic [31:0] exp);
        int          pc  = 0;
        int          idx = 0;
        int          ok  = 1;
        logic [31:0] word = '0;
        for (int b = 0; b < dw; b++) pc += int'(exp[b]);
        chk({tag, " env_len"}, len, LEAD + dw * 2 * hb + TAIL);
        chk({tag, " toggles"}, n, dw + pc + 1);
        chk({tag, " first_edge"}, t[0], LEAD);
        for (int b = 0; b < dw; b++) begin
            if (idx >= n || idx >= 80 || t[idx] != LEAD + 2 * hb * b) ok = 0;
            if (idx + 1 < n && idx + 1 < 80 && t[idx+1] == LEAD + 2 * hb * b + hb) begin
                word = {word[30:0], 1'b1};
                idx += 2;
            end else begin
                word = {word[30:0], 1'b0};
                idx += 1;
            end
        end
        if (idx >= n || idx >= 80 || t[idx] != LEAD + 2 * hb * dw || idx + 1 != n) ok = 0;
        chk({tag, " decode"}, word, exp);
        chk({tag, " spacing"}, ok, 1);
    endtask

    // Line monitor for the default-parameter DUT.
    int          tog1[80];
    int          n1 = 0, len1 = 0, last_fall = 0, last_gap = 0;
    logic        in1 = 1'b0, penv1 = 1'b0, pdat1 = 1'b0;
    logic [31:0] e1;
    always @(negedge clk_25MHz) begin
        if (!reset_n) begin
            in1 = 1'b0; penv1 = 1'b0; pdat1 = data_wire;
        end else begin
            if (envelop_wire && !penv1) begin
                in1 = 1'b1; len1 = 0; n1 = 0; last_gap = cyc - last_fall;
            end
            if (in1) begin
                if (envelop_wire) begin
                    if (data_wire !== pdat1) begin
                        if (n1 < 80) tog1[n1] = len1;
                        n1++;
                    end
                    len1++;
                end else begin
                    in1 = 1'b0; last_fall = cyc;
                    chk("main sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e1 = sb.pop_front();
                        check_frame("main", len1, n1, tog1, H, DW, e1);
                    end
                end
            end
            penv1 = envelop_wire; pdat1 = data_wire;
        end
    end

    // Line monitor for the narrow, fast DUT.
    int          tog2[80];
    int          n2 = 0, len2 = 0;
    logic        in2 = 1'b0, penv2 = 1'b0, pdat2 = 1'b0;
    logic [31:0] e2;
    always @(negedge clk_25MHz) begin
        if (!reset_n) begin
            in2 = 1'b0; penv2 = 1'b0; pdat2 = data_wire2;
        end else begin
            if (envelop_wire2 && !penv2) begin
                in2 = 1'b1; len2 = 0; n2 = 0;
            end
            if (in2) begin
                if (envelop_wire2) begin
                    if (data_wire2 !== pdat2) begin
                        if (n2 < 80) tog2[n2] = len2;
                        n2++;
                    end
                    len2++;
                end else begin
                    in2 = 1'b0;
                    chk("small sb_nonempty", sb2.size() > 0, 1);
                    if (sb2.size() > 0) begin
                        e2 = sb2.pop_front();
                        check_frame("small", len2, n2, tog2, H2, DW2, e2);
                    end
                end
            end
            penv2 = envelop_wire2; pdat2 = data_wire2;
        end
    end

    task automatic send(input logic [DW-1:0] w);
        int t = 0;
        @(negedge clk_25MHz);
        tx_data = w; tx_valid = 1'b1; sb.push_back(32'(w));
        while (!tx_ready && t < 1000) begin @(negedge clk_25MHz); t++; end
        chk("accept timeout", t < 1000, 1);
        @(posedge clk_25MHz); #1;
        tx_valid = 1'b0;
        tx_data  = DW'($urandom);
        chk("env at accept+1", envelop_wire, 1);
        chk("ready drop", tx_ready, 0);
        chk("busy at accept+1", busy, 1);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while ((busy !== 1'b0 || tx_ready !== 1'b1) && t < 2000) begin
            @(negedge clk_25MHz); t++;
        end
        chk({tag, " idle timeout"}, t < 2000, 1);
        @(negedge clk_25MHz);
    endtask

    initial begin
        int t;
        // Reset values
        #50;
        chk("rst data_wire", data_wire, 0);
        chk("rst envelop_wire", envelop_wire, 0);
        chk("rst tx_ready", tx_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst small tx_ready", tx_ready2, 1);
        chk("rst small envelop", envelop_wire2, 0);
        @(negedge clk_25MHz); reset_n = 1'b1;
        repeat (2) @(negedge clk_25MHz);

        // All zeros, then all ones (line level follows toggle parity)
        send(17'h00000); wait_idle("t1");
        chk("t1 data level after", data_wire, 0);
        send(17'h1FFFF); wait_idle("t2");
        chk("t2 data level after", data_wire, 1);

        // Mixed word with a mid-frame tx_valid pulse that must be ignored
        send(17'h1B2D5);
        repeat (100) @(negedge clk_25MHz);
        tx_data = 17'h00F0F; tx_valid = 1'b1;
        @(negedge clk_25MHz);
        tx_valid = 1'b0;
        chk("t3 ready low mid", tx_ready, 0);
        wait_idle("t3");
        repeat (5) @(negedge clk_25MHz);
        chk("t3 no extra frame", envelop_wire, 0);

        // Back-to-back with tx_valid held high
        @(negedge clk_25MHz);
        tx_data = 17'h0AAAA; tx_valid = 1'b1; sb.push_back(32'h0AAAA);
        t = 0;
        while (!tx_ready && t < 1000) begin @(negedge clk_25MHz); t++; end
        chk("t4 A accept timeout", t < 1000, 1);
        @(posedge clk_25MHz); #1;
        tx_data = 17'h15555; sb.push_back(32'h15555);
        repeat (50) @(negedge clk_25MHz);
        chk("t4 ready low during A", tx_ready, 0);
        t = 0;
        while (!tx_ready && t < 1000) begin @(negedge clk_25MHz); t++; end
        chk("t4 B accept timeout", t < 1000, 1);
        @(posedge clk_25MHz); #1;
        tx_valid = 1'b0;
        chk("t4 B env rise", envelop_wire, 1);
        chk("t4 B ready drop", tx_ready, 0);
        wait_idle("t4");
        chk("t4 idle gap", last_gap, 1);

        // Asynchronous reset in bit 9
        send(17'h0F0F0);
        repeat (LEAD + 2 * H * 9 + 3) @(posedge clk_25MHz);
        #7;
        chk("t5 env before reset", envelop_wire, 1);
        reset_n = 1'b0;
        #1;
        chk("t5 rst data_wire", data_wire, 0);
        chk("t5 rst envelop_wire", envelop_wire, 0);
        chk("t5 rst tx_ready", tx_ready, 1);
        chk("t5 rst busy", busy, 0);
        void'(sb.pop_back());
        repeat (3) @(negedge clk_25MHz);
        reset_n = 1'b1;
        @(negedge clk_25MHz);
        send(17'h00001); wait_idle("t5");

        // Narrow word, short half bit
        @(negedge clk_25MHz);
        tx_data2 = 8'hA5; tx_valid2 = 1'b1; sb2.push_back(32'hA5);
        t = 0;
        while (!tx_ready2 && t < 1000) begin @(negedge clk_25MHz); t++; end
        chk("t6 accept timeout", t < 1000, 1);
        @(posedge clk_25MHz); #1;
        tx_valid2 = 1'b0;
        chk("t6 env at accept+1", envelop_wire2, 1);
        t = 0;
        while (busy2 !== 1'b0 && t < 1000) begin @(negedge clk_25MHz); t++; end
        chk("t6 idle timeout", t < 1000, 1);
        repeat (2) @(negedge clk_25MHz);

        chk("main sb drained", sb.size(), 0);
        chk("small sb drained", sb2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
